// File: rtl/factorial_pkg.sv
// Shared types and constants for the iterative factorial engine.
// Holds the FSM encoding, result-mode codes and the DATA_W legality rule.
package factorial_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic MODE_WRAP = 1'b0;
  localparam logic MODE_SAT  = 1'b1;

  localparam int unsigned DATA_W_MIN = 8;
  localparam int unsigned DATA_W_MAX = 64;

  function automatic bit data_w_legal(input int unsigned w);
    return (w >= DATA_W_MIN) && (w <= DATA_W_MAX);
  endfunction

endpackage

// File: rtl/factorial_mul_ovf.sv
// Combinational DATA_W x DATA_W multiply: low word of the product plus a flag
// that is set when any bit of the upper word is nonzero.
module factorial_mul_ovf #(
  parameter int unsigned DATA_W = 32
) (
  input  logic [DATA_W-1:0] i_a,
  input  logic [DATA_W-1:0] i_b,
  output logic [DATA_W-1:0] o_lo,
  output logic              o_hi
);

  logic [2*DATA_W-1:0] w_prod;

  assign w_prod = {{DATA_W{1'b0}}, i_a} * {{DATA_W{1'b0}}, i_b};
  assign o_lo   = w_prod[DATA_W-1:0];
  assign o_hi   = |w_prod[2*DATA_W-1:DATA_W];

endmodule

// File: rtl/factorial_iter_param.sv
// Iterative num! engine, one multiply per cycle, ap_ctrl_hs handshake.
// Per-call wrap/saturate mode, sticky overflow and early exit once a wrapped residue hits 0.
module factorial_iter_param
  import factorial_pkg::*;
#(
  parameter int unsigned DATA_W = 32
) (
  input  logic              ap_clk,
  input  logic              ap_rst,
  input  logic              ap_start,
  output logic              ap_done,
  output logic              ap_idle,
  output logic              ap_ready,
  input  logic [DATA_W-1:0] num,
  input  logic              mode,
  output logic [DATA_W-1:0] ap_return,
  output logic              ap_overflow
);

  if (!data_w_legal(DATA_W)) begin : g_bad_data_w
    $error("factorial_iter_param: DATA_W must be within 8..64");
  end

  localparam logic [DATA_W-1:0] AccOne  = DATA_W'(1);
  localparam logic [DATA_W-1:0] AllOnes = '1;

  state_t              r_state, w_state_next;
  logic [DATA_W-1:0]   r_acc, w_acc_next;
  logic [DATA_W-1:0]   r_cnt, w_cnt_next;
  logic                r_ovf, w_ovf_next;
  logic                r_mode, w_mode_next;
  logic [DATA_W-1:0]   r_ret, w_ret_next;
  logic                r_ret_ovf, w_ret_ovf_next;

  logic [DATA_W-1:0]   w_prod_lo;
  logic                w_prod_hi;
  logic                w_accept;
  logic                w_cnt_le1;
  logic                w_wrap_zero;
  logic                w_sat_ovf;

  factorial_mul_ovf #(
    .DATA_W (DATA_W)
  ) u_mul (
    .i_a  (r_acc),
    .i_b  (r_cnt),
    .o_lo (w_prod_lo),
    .o_hi (w_prod_hi)
  );

  assign w_accept    = (r_state == ST_IDLE) && ap_start;
  assign w_cnt_le1   = (r_cnt[DATA_W-1:1] == '0);
  assign w_wrap_zero = (r_mode == MODE_WRAP) && (r_acc == '0);
  assign w_sat_ovf   = (r_mode == MODE_SAT) && w_prod_hi;

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      ST_IDLE: if (ap_start) w_state_next = ST_CALC;
      ST_CALC: if (w_cnt_le1 || w_wrap_zero || w_sat_ovf) w_state_next = ST_DONE;
      ST_DONE: w_state_next = ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Reset gates ap_ready so nothing is reported as accepted while reset is held.
  always_comb begin
    ap_idle     = (r_state == ST_IDLE);
    ap_ready    = ap_idle && ap_start && !ap_rst;
    ap_done     = (r_state == ST_DONE);
    ap_return   = r_ret;
    ap_overflow = r_ret_ovf;
  end

  // Datapath next-state; the result registers load on the CALC->DONE transition.
  always_comb begin
    w_acc_next     = r_acc;
    w_cnt_next     = r_cnt;
    w_ovf_next     = r_ovf;
    w_mode_next    = r_mode;
    w_ret_next     = r_ret;
    w_ret_ovf_next = r_ret_ovf;
    if (w_accept) begin
      w_acc_next  = AccOne;
      w_cnt_next  = num;
      w_ovf_next  = 1'b0;
      w_mode_next = mode;
    end else if (r_state == ST_CALC) begin
      if (w_cnt_le1 || w_wrap_zero) begin
        w_ret_next     = r_acc;
        w_ret_ovf_next = r_ovf;
      end else if (r_mode == MODE_WRAP) begin
        w_acc_next = w_prod_lo;
        w_ovf_next = r_ovf | w_prod_hi;
        w_cnt_next = r_cnt - AccOne;
      end else if (w_prod_hi) begin
        w_acc_next     = AllOnes;
        w_ovf_next     = 1'b1;
        w_ret_next     = AllOnes;
        w_ret_ovf_next = 1'b1;
      end else begin
        w_acc_next = w_prod_lo;
        w_cnt_next = r_cnt - AccOne;
      end
    end
  end

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      r_acc     <= AccOne;
      r_cnt     <= '0;
      r_ovf     <= 1'b0;
      r_mode    <= MODE_WRAP;
      r_ret     <= '0;
      r_ret_ovf <= 1'b0;
    end else begin
      r_acc     <= w_acc_next;
      r_cnt     <= w_cnt_next;
      r_ovf     <= w_ovf_next;
      r_mode    <= w_mode_next;
      r_ret     <= w_ret_next;
      r_ret_ovf <= w_ret_ovf_next;
    end
  end

endmodule

// File: tb/tb_factorial_iter_param.sv
// Bench for factorial_iter_param: directed table, handshake/reset sequences and
// randomized calls against an arithmetic factorial model, at DATA_W=32 and DATA_W=8.
module tb_factorial_iter_param;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] tb_num;
  logic        tb_mode;
  logic        sel8;

  logic        d32_done, d32_idle, d32_ready, d32_ovf;
  logic [31:0] d32_ret;
  logic        d8_done, d8_idle, d8_ready, d8_ovf;
  logic [7:0]  d8_ret;

  logic        obs_done, obs_idle, obs_ready, obs_ovf;
  logic [31:0] obs_ret;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  factorial_iter_param #(.DATA_W(32)) u_dut32 (
    .ap_clk      (clk),
    .ap_rst      (rst),
    .ap_start    (start && !sel8),
    .ap_done     (d32_done),
    .ap_idle     (d32_idle),
    .ap_ready    (d32_ready),
    .num         (tb_num),
    .mode        (tb_mode),
    .ap_return   (d32_ret),
    .ap_overflow (d32_ovf)
  );

  factorial_iter_param #(.DATA_W(8)) u_dut8 (
    .ap_clk      (clk),
    .ap_rst      (rst),
    .ap_start    (start && sel8),
    .ap_done     (d8_done),
    .ap_idle     (d8_idle),
    .ap_ready    (d8_ready),
    .num         (tb_num[7:0]),
    .mode        (tb_mode),
    .ap_return   (d8_ret),
    .ap_overflow (d8_ovf)
  );

  assign obs_done  = sel8 ? d8_done  : d32_done;
  assign obs_idle  = sel8 ? d8_idle  : d32_idle;
  assign obs_ready = sel8 ? d8_ready : d32_ready;
  assign obs_ovf   = sel8 ? d8_ovf   : d32_ovf;
  assign obs_ret   = sel8 ? {24'd0, d8_ret} : d32_ret;

  typedef struct {
    bit          w8;
    logic [31:0] n;
    bit          m;
    logic [31:0] ret;
    bit          ovf;
    int          lat;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: multiply num, num-1, ..., 2 with plain arithmetic. Latency is
  // two cycles plus the number of factors folded in before the call ends.
  task automatic model(input longint unsigned n, input bit m, input int w,
                       output logic [31:0] ret, output bit ovf, output int lat);
    longint unsigned mask = (64'd1 << w) - 64'd1;
    longint unsigned acc  = 1;
    longint unsigned p;
    int steps = 0;
    ovf = 1'b0;
    for (longint unsigned i = n; i >= 2; i--) begin
      p = acc * i;
      if (m) begin
        if (p > mask) begin
          acc = mask;
          ovf = 1'b1;
          break;
        end
        acc = p;
        steps++;
      end else begin
        if (p > mask) ovf = 1'b1;
        acc = p & mask;
        steps++;
        if (acc == 0) break;
      end
    end
    ret = acc[31:0];
    lat = steps + 2;
  endtask

  task automatic wait_done(output int lat);
    lat = 1;
    while (!obs_done && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    if (lat >= 100) begin
      n_vec++;
      n_bad++;
      $display("FAIL timeout: no ap_done within %0d cycles, expected a pulse", lat);
    end
  endtask

  // Accept happens at the first posedge; inputs are scrambled right after it.
  task automatic run_call(input logic [31:0] n, input bit m, input string name,
                          output logic [31:0] ret, output bit ovf, output int lat);
    @(negedge clk);
    start   = 1'b1;
    tb_num  = n;
    tb_mode = m;
    #1;
    check({name, " ready"}, obs_ready, 1);
    check({name, " idle"}, obs_idle, 1);
    @(negedge clk);
    start   = 1'b0;
    tb_num  = $urandom;
    tb_mode = 1'($urandom);
    wait_done(lat);
    ret = obs_ret;
    ovf = obs_ovf;
    @(negedge clk);
    check({name, " done_pulse"}, obs_done, 0);
  endtask

  initial begin
    logic [31:0] r, er;
    bit          o, eo;
    int          l, el, cnt;

    vecs[0]  = '{1'b0, 32'd5,          1'b0, 32'd120,        1'b0, 6};
    vecs[1]  = '{1'b0, 32'd12,         1'b0, 32'd479001600,  1'b0, 13};
    vecs[2]  = '{1'b0, 32'd13,         1'b0, 32'd1932053504, 1'b1, 14};
    vecs[3]  = '{1'b0, 32'd13,         1'b1, 32'hFFFFFFFF,   1'b1, 13};
    vecs[4]  = '{1'b0, 32'd0,          1'b0, 32'd1,          1'b0, 2};
    vecs[5]  = '{1'b0, 32'd0,          1'b1, 32'd1,          1'b0, 2};
    vecs[6]  = '{1'b0, 32'd1,          1'b0, 32'd1,          1'b0, 2};
    vecs[7]  = '{1'b0, 32'd1,          1'b1, 32'd1,          1'b0, 2};
    vecs[8]  = '{1'b0, 32'hFFFFFFFF,   1'b0, 32'd0,          1'b1, 36};
    vecs[9]  = '{1'b1, 32'd6,          1'b0, 32'd208,        1'b1, 7};
    vecs[10] = '{1'b1, 32'd6,          1'b1, 32'd255,        1'b1, 5};
    vecs[11] = '{1'b1, 32'd5,          1'b0, 32'd120,        1'b0, 6};

    rst = 1'b1; start = 1'b1; tb_num = 32'd0; tb_mode = 1'b0; sel8 = 1'b0;
    #12;
    check("rst idle", obs_idle, 1);
    check("rst ready", obs_ready, 0);
    check("rst done", obs_done, 0);
    check("rst ret", obs_ret, 0);
    check("rst ovf", obs_ovf, 0);
    @(negedge clk);
    rst = 1'b0; start = 1'b0;

    foreach (vecs[i]) begin
      sel8 = vecs[i].w8;
      run_call(vecs[i].n, vecs[i].m, $sformatf("vec%0d", i), r, o, l);
      check($sformatf("vec%0d ret", i), r, vecs[i].ret);
      check($sformatf("vec%0d ovf", i), o, vecs[i].ovf);
      check($sformatf("vec%0d lat", i), l, vecs[i].lat);
    end
    sel8 = 1'b0;

    // Result held while idle; num/mode changed after accept have no effect.
    run_call(32'd6, 1'b0, "hold", r, o, l);
    check("hold ret", r, 720);
    repeat (3) @(negedge clk);
    check("hold idle", obs_idle, 1);
    check("hold ret later", obs_ret, 720);

    // ap_start held high: next ap_ready exactly one cycle after ap_done.
    @(negedge clk);
    start = 1'b1; tb_num = 32'd3; tb_mode = 1'b0;
    @(negedge clk);
    wait_done(l);
    check("b2b ret", obs_ret, 6);
    check("b2b ready in done", obs_ready, 0);
    @(negedge clk);
    check("b2b done width", obs_done, 0);
    check("b2b ready next", obs_ready, 1);
    @(negedge clk);
    start = 1'b0;
    wait_done(l);
    check("b2b second ret", obs_ret, 6);
    @(negedge clk);

    // Asynchronous reset in the middle of a num=10 call.
    @(negedge clk);
    start = 1'b1; tb_num = 32'd10; tb_mode = 1'b0;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("pre-rst busy", obs_idle, 0);
    @(posedge clk);
    #2 rst = 1'b1; start = 1'b1;
    #1;
    check("mid rst idle", obs_idle, 1);
    check("mid rst done", obs_done, 0);
    check("mid rst ready", obs_ready, 0);
    check("mid rst ret", obs_ret, 0);
    check("mid rst ovf", obs_ovf, 0);
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    cnt = 0;
    repeat (15) begin
      @(negedge clk);
      if (obs_done) cnt++;
    end
    check("no done after rst", cnt, 0);
    run_call(32'd4, 1'b0, "post rst", r, o, l);
    check("post rst ret", r, 24);
    check("post rst ovf", o, 0);

    for (int k = 0; k < 24; k++) begin
      logic [31:0] n;
      bit          m;
      sel8 = 1'($urandom);
      m    = 1'($urandom);
      n    = ($urandom_range(0, 3) == 0) ? $urandom : $urandom_range(0, 24);
      if (sel8) n = n & 32'hFF;
      model(n, m, sel8 ? 8 : 32, er, eo, el);
      run_call(n, m, $sformatf("rnd%0d", k), r, o, l);
      check($sformatf("rnd%0d ret n=%0h m=%0d w8=%0d", k, n, m, sel8), r, er);
      check($sformatf("rnd%0d ovf", k), o, eo);
      check($sformatf("rnd%0d lat", k), l, el);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/factorial_iter_param.md
Name: factorial_iter_param

Overview:
- Parametrised, iterative factorial engine with the ap_ctrl_hs block-level handshake (ap_start/ap_done/ap_idle/ap_ready).
- Computes num! with one multiply per cycle.
- Generalises the fixed 32-bit factorial core:
  - configurable data width
  - per-call result mode: wrap modulo 2^DATA_W, or saturate
  - sticky overflow flag
  - bounded-latency early termination
- Drop-in replacement for the 32-bit core at DATA_W=32; the top-level wrapper instantiates it.

Parameters:
- DATA_W, 32, width of num, accumulator and ap_return; legal range 8..64.

Ports:
- ap_clk  in  1  clock, rising-edge.
- ap_rst  in  1  reset, asynchronous, active-high.
- ap_start  in  1  request; sampled only in IDLE.
- ap_done  out  1  one-cycle pulse when ap_return/ap_overflow are valid.
- ap_idle  out  1  high while in IDLE.
- ap_ready  out  1  high in the cycle num/mode are accepted.
- num  in  DATA_W  operand, unsigned; sampled at accept.
- mode  in  1  0=wrap (mod 2^DATA_W), 1=saturate; sampled at accept.
- ap_return  out  DATA_W  result; registered; held until next ap_done.
- ap_overflow  out  1  set if true num! >= 2^DATA_W; registered with ap_return.

Behaviour:
- Reset (async, ap_rst=1) applies to any state, including mid-CALC; the in-flight call is discarded.
  - state=IDLE, acc=1, cnt=0.
  - ap_return=0, ap_overflow=0, ap_done=0, ap_ready=0, ap_idle=1.
- States: IDLE, CALC, DONE.
- IDLE:
  - ap_idle=1.
  - ap_ready = ap_start (combinational).
  - On ap_start=1: cnt<=num, acc<=1, ovf<=0, mode_r<=mode; go CALC.
- CALC, priority order each cycle:
  1. cnt<=1 -> DONE, result=acc.
  2. mode_r=0 and acc==0 -> DONE, result=0 (early termination; the residue can no longer change).
  3. Otherwise multiply, with p = acc*cnt at full 2*DATA_W bits and hi = p[2*DATA_W-1:DATA_W] != 0:
     - wrap: acc<=p[DATA_W-1:0]; ovf<=ovf|hi; cnt<=cnt-1.
     - saturate and hi: acc<=all ones; ovf<=1; go DONE immediately (counts as the final cycle).
     - saturate, no hi: acc<=p low; cnt<=cnt-1.
- DONE:
  - ap_done=1 for exactly one cycle.
  - ap_return<=acc and ap_overflow<=ovf are registered on entry to DONE, so they are visible while ap_done=1.
  - Always returns to IDLE next cycle.
  - ap_start is ignored in DONE; back-to-back calls have one IDLE cycle between ap_done and the next ap_ready.
- Latency, with accept in cycle T:
  - No early exit: ap_done in cycle T+max(num,1)+1. num=0 and num=1 return 1 at T+2.
  - Wrap mode: the acc==0 exit bounds latency for any num, e.g. at most about 40 CALC cycles for DATA_W=32.
- ap_overflow in wrap mode:
  - Set only if some partial product exceeded DATA_W bits.
  - Wrap results are exact mod 2^DATA_W.
  - An acc==0 early exit implies ovf=1.
- num and mode may change freely after accept without effect.
- ap_idle=0 in CALC and DONE; ap_ready=0 outside IDLE.

Decomposition:
- Shared package factorial_pkg:
  - state enum {ST_IDLE, ST_CALC, ST_DONE}
  - MODE_WRAP=1'b0, MODE_SAT=1'b1
  - parameter legality checks (DATA_W range)
- One sub-module, factorial_mul_ovf: combinational DATA_W x DATA_W multiply returning the low word and the hi-nonzero flag; parametrised by DATA_W.
- The FSM, counter and output registers stay in the top.

Test Plan:
- DATA_W=32, mode=0, num=5, start at T -> ap_ready at T, ap_done at T+6, ap_return=120, ap_overflow=0. Repeat with num=12 -> 479001600, ovf=0, done at T+13.
- DATA_W=32, num=13: mode=0 -> ap_return=1932053504 (13! mod 2^32), ovf=1, done at T+14. mode=1 -> ap_return=0xFFFFFFFF, ovf=1, done before T+14.
- num=0 and num=1, both modes -> ap_return=1, ovf=0, ap_done at T+2. ap_start held high continuously -> next ap_ready exactly one cycle after ap_done; ap_done never lasts more than 1 cycle.
- DATA_W=32, mode=0, num=0xFFFFFFFF -> ap_return=0, ovf=1, ap_done within 40 cycles. DATA_W=8: num=6 mode=0 -> 208, ovf=1; mode=1 -> 255, ovf=1.
- Assert ap_rst asynchronously (between clock edges) mid-CALC of num=10:
  - Outputs return immediately to the reset values above; no ap_done pulse.
  - A subsequent num=4 call returns 24 with ovf=0.
- Change num/mode on the cycle after accept -> result reflects the accepted values only; ap_return holds its value between calls while ap_idle=1.
